// File: rtl/fdc_cmd_master_if.sv
// ============================================================================
//  Module      : fdc_cmd_master_if
//  Description : CPU-port bus between the FDC command master and a
//                uPD765-style floppy disk controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fdc_cmd_master_if;
    logic       fdc_ce;
    logic       fdc_a0;
    logic       fdc_rd_n;
    logic       fdc_wr_n;
    logic [7:0] fdc_dout;
    logic [7:0] fdc_din;

    modport master (
        output fdc_ce,
        output fdc_a0,
        output fdc_rd_n,
        output fdc_wr_n,
        output fdc_dout,
        input  fdc_din
    );

    modport slave (
        input  fdc_ce,
        input  fdc_a0,
        input  fdc_rd_n,
        input  fdc_wr_n,
        input  fdc_dout,
        output fdc_din
    );
endinterface

`default_nettype wire

// File: rtl/fdc_cmd_master.sv
// ============================================================================
//  Module      : fdc_cmd_master
//  Description : Executes one complete uPD765 command over the FDC CPU port:
//                MSR-polled command phase followed by MSR-polled result phase.
//                Host loads a 9-byte command buffer, pulses start, and reads
//                up to 8 result bytes after done.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fdc_cmd_master #(
    parameter int STROBE_CYCLES = 3,
    parameter int TIMEOUT       = 65535
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       cmd_wr,
    input  wire logic [7:0] cmd_data,
    input  wire logic       start,
    input  wire logic [2:0] res_idx,
    output logic      [7:0] res_data,
    output logic      [3:0] res_count,
    output logic            busy,
    output logic            done,
    output logic            timeout,
    output logic            early_result,
    fdc_cmd_master_if.master fdc
);

    localparam int              SW    = $clog2(STROBE_CYCLES);
    localparam logic [SW-1:0]   SLAST = SW'(STROBE_CYCLES - 1);
    localparam logic [15:0]     TLIM  = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD_POLL, S_CMD_WRITE, S_RES_POLL, S_RES_READ, S_FINISH
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_LOW, PH_HIGH, PH_GAP} phase_t;

    state_t      state, state_n;
    phase_t      phase, phase_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [15:0] poll_cnt;
    logic [7:0]  cmd_buf [0:8];
    logic [3:0]  cmd_count;
    logic [3:0]  cmd_ptr;
    logic [7:0]  res_buf [0:7];
    logic [2:0]  msr_q;          // {RQM, DIO, CB} from the last MSR read

    logic        bus_act, bus_end, sample, start_ok, poll_exp;
    logic        set_to, set_early, poll_clr, poll_inc;
    logic [15:0] poll_next;
    logic [3:0]  wr_idx;

    assign bus_act   = (state == S_CMD_POLL) || (state == S_CMD_WRITE) ||
                       (state == S_RES_POLL) || (state == S_RES_READ);
    assign bus_end   = bus_act && (phase == PH_GAP);
    // FDC registers dout one cycle after the falling edge, so take it late.
    assign sample    = bus_act && (phase == PH_LOW) && (scnt == SLAST);
    assign start_ok  = start && !busy;
    assign poll_next = poll_cnt + 16'd1;
    assign poll_exp  = (poll_next == TLIM);
    assign wr_idx    = (state == S_FINISH) ? 4'd0 : cmd_count;

    // Strobes decode straight from async-reset registers so reset drops them at once.
    assign busy         = bus_act;
    assign done         = (state == S_FINISH);
    assign fdc.fdc_ce   = bus_act && (phase != PH_GAP);
    assign fdc.fdc_a0   = (state == S_CMD_WRITE) || (state == S_RES_READ);
    assign fdc.fdc_wr_n = !((state == S_CMD_WRITE) && (phase == PH_LOW));
    assign fdc.fdc_rd_n = !(bus_act && (state != S_CMD_WRITE) && (phase == PH_LOW));
    assign fdc.fdc_dout = (state == S_CMD_WRITE) ? cmd_buf[cmd_ptr] : 8'h00;

    // State, bus phase and strobe-width counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            phase <= PH_SETUP;
            scnt  <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            scnt  <= scnt_n;
        end
    end

    // Bus-cycle sequencing and command/result phase decisions at each bus-cycle end.
    always_comb begin
        state_n   = state;
        phase_n   = PH_SETUP;
        scnt_n    = '0;
        set_to    = 1'b0;
        set_early = 1'b0;
        poll_clr  = 1'b0;
        poll_inc  = 1'b0;

        if (bus_act) begin
            case (phase)
                PH_SETUP: phase_n = PH_LOW;
                PH_LOW: begin
                    phase_n = (scnt == SLAST) ? PH_HIGH : PH_LOW;
                    scnt_n  = (scnt == SLAST) ? '0 : scnt + 1'b1;
                end
                PH_HIGH: begin
                    phase_n = (scnt == SLAST) ? PH_GAP : PH_HIGH;
                    scnt_n  = (scnt == SLAST) ? '0 : scnt + 1'b1;
                end
                default: phase_n = PH_SETUP;
            endcase
        end

        case (state)
            S_IDLE: begin
                if (start)
                    state_n = (cmd_count == 4'd0) ? S_FINISH : S_CMD_POLL;
            end
            S_CMD_POLL: begin
                if (bus_end) begin
                    if (msr_q[2] && !msr_q[1]) begin
                        state_n = S_CMD_WRITE;
                    end else if (poll_exp) begin
                        set_to  = 1'b1;
                        state_n = S_FINISH;
                    end else if (msr_q[2] && msr_q[1]) begin
                        // FDC rejected the command early (e.g. invalid opcode).
                        set_early = 1'b1;
                        poll_inc  = 1'b1;
                        state_n   = S_RES_POLL;
                    end else begin
                        poll_inc = 1'b1;
                    end
                end
            end
            S_CMD_WRITE: begin
                if (bus_end) begin
                    poll_clr = 1'b1;
                    state_n  = ((cmd_ptr + 4'd1) < cmd_count) ? S_CMD_POLL : S_RES_POLL;
                end
            end
            S_RES_POLL: begin
                if (bus_end) begin
                    if (!msr_q[0]) begin
                        state_n = S_FINISH;
                    end else if (msr_q[2] && msr_q[1]) begin
                        state_n = S_RES_READ;
                    end else if (poll_exp) begin
                        set_to  = 1'b1;
                        state_n = S_FINISH;
                    end else begin
                        poll_inc = 1'b1;
                    end
                end
            end
            S_RES_READ: begin
                if (bus_end) begin
                    poll_clr = 1'b1;
                    state_n  = S_RES_POLL;
                end
            end
            S_FINISH: begin
                // Buffer empties with done, so a start here is an empty command.
                state_n = start ? S_FINISH : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Command buffer fill, drain pointer, poll counter and MSR capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) cmd_buf[i] <= 8'h00;
            cmd_count <= 4'd0;
            cmd_ptr   <= 4'd0;
            poll_cnt  <= 16'd0;
            msr_q     <= 3'd0;
        end else begin
            if (cmd_wr && !busy && ((state == S_FINISH) || (cmd_count < 4'd9)))
                cmd_buf[wr_idx] <= cmd_data;
            if (state == S_FINISH)
                cmd_count <= cmd_wr ? 4'd1 : 4'd0;
            else if (cmd_wr && !busy && (cmd_count < 4'd9))
                cmd_count <= cmd_count + 4'd1;

            if (start_ok)
                cmd_ptr <= 4'd0;
            else if ((state == S_CMD_WRITE) && bus_end)
                cmd_ptr <= cmd_ptr + 4'd1;

            if (start_ok || poll_clr)
                poll_cnt <= 16'd0;
            else if (poll_inc)
                poll_cnt <= poll_next;

            if (sample)
                msr_q <= {fdc.fdc_din[7], fdc.fdc_din[6], fdc.fdc_din[4]};
        end
    end

    // Result capture, status flags and registered result read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) res_buf[i] <= 8'h00;
            res_count    <= 4'd0;
            res_data     <= 8'h00;
            timeout      <= 1'b0;
            early_result <= 1'b0;
        end else begin
            if (start_ok) begin
                res_count <= 4'd0;
            end else if (sample && (state == S_RES_READ)) begin
                if (!res_count[3])
                    res_buf[res_count[2:0]] <= fdc.fdc_din;
                if (res_count != 4'd8)
                    res_count <= res_count + 4'd1;
            end

            if (start_ok)    timeout <= 1'b0;
            else if (set_to) timeout <= 1'b1;

            if (start_ok)       early_result <= 1'b0;
            else if (set_early) early_result <= 1'b1;

            res_data <= res_buf[res_idx];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fdc_cmd_master.sv
// ============================================================================
//  Module      : tb_fdc_cmd_master
//  Description : Self-checking bench for fdc_cmd_master with a small
//                behavioural uPD765 CPU-port model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fdc_cmd_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_wr;
    logic [7:0] cmd_data;
    logic       start;
    logic [2:0] res_idx;
    logic [7:0] res_data;
    logic [3:0] res_count;
    logic       busy, done, timeout, early_result;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    fdc_cmd_master_if fdc ();

    fdc_cmd_master #(.STROBE_CYCLES(3), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_wr       (cmd_wr),
        .cmd_data     (cmd_data),
        .start        (start),
        .res_idx      (res_idx),
        .res_data     (res_data),
        .res_count    (res_count),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .early_result (early_result),
        .fdc          (fdc)
    );

    // ---------------- FDC model ----------------
    bit         m_stuck;
    bit         m_resph;
    int         m_nbytes, m_need, m_rcnt, m_rptr, m_writes, m_msr_reads;
    logic [7:0] m_first, m_last_msr;
    logic [7:0] m_res [0:3];
    logic [7:0] msr;

    assign msr = m_stuck ? 8'h10 : (m_resph ? 8'hD0 : ((m_nbytes > 0) ? 8'h90 : 8'h80));
    assign fdc.fdc_din = fdc.fdc_a0 ? m_res[m_rptr[1:0]] : msr;

    task automatic m_reset(input bit stuck);
        m_stuck = stuck; m_resph = 0; m_nbytes = 0; m_need = 0;
        m_rcnt = 0; m_rptr = 0; m_writes = 0; m_msr_reads = 0;
        m_first = 8'h00; m_last_msr = 8'h00;
        for (int i = 0; i < 4; i++) m_res[i] = 8'h00;
    endtask

    always @(posedge fdc.fdc_wr_n) begin
        if (!rst && fdc.fdc_ce && fdc.fdc_a0) begin
            m_writes++;
            if (!m_resph) begin
                if (m_nbytes == 0) begin
                    m_first = fdc.fdc_dout;
                    case (fdc.fdc_dout)
                        8'h04:   m_need = 2;
                        8'h03:   m_need = 3;
                        8'h08:   m_need = 1;
                        default: m_need = 0;
                    endcase
                end
                m_nbytes++;
                m_rptr = 0;
                if (m_need == 0) begin
                    m_res[0] = 8'h80; m_rcnt = 1; m_resph = 1; m_nbytes = 0;
                end else if (m_nbytes == m_need) begin
                    case (m_first)
                        8'h04: begin m_res[0] = 8'h20 | (fdc.fdc_dout & 8'h07); m_rcnt = 1; end
                        8'h08: begin m_res[0] = 8'h20; m_res[1] = 8'h05; m_rcnt = 2; end
                        default: m_rcnt = 0;
                    endcase
                    m_nbytes = 0;
                    m_resph  = (m_rcnt != 0);
                end
            end
        end
    end

    always @(posedge fdc.fdc_rd_n) begin
        if (!rst && fdc.fdc_ce) begin
            if (!fdc.fdc_a0) begin
                m_msr_reads++;
                m_last_msr = msr;
            end else begin
                m_rptr++;
                if (m_rptr >= m_rcnt) m_resph = 0;
            end
        end
    end

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk); cmd_wr = 1'b1; cmd_data = b;
        @(negedge clk); cmd_wr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) chk({nm, "_done_wait"}, 32'd0, 32'd1);
    endtask

    task automatic read_res(input logic [2:0] idx, output logic [7:0] v);
        @(negedge clk); res_idx = idx;
        @(negedge clk); v = res_data;
    endtask

    typedef struct {
        string      name;
        logic [7:0] b0, b1, b2;
        int         n;
        bit         stuck;
        int         exp_wr;
        int         exp_cnt;
        logic [7:0] r0, r1;
        int         nchk;
        bit         exp_to, exp_early;
        logic [7:0] exp_last;
        int         exp_reads;   // -1 = not checked
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] rv;
    int         n;

    initial begin
        // name, b0, b1, b2, n, stuck, writes, cnt, r0, r1, nchk, to, early, last MSR, MSR reads
        vecs[0] = '{"sds",     8'h04, 8'h00, 8'h00, 2, 0, 2, 1, 8'h20, 8'h00, 1, 0, 0, 8'h80, -1};
        vecs[1] = '{"specify", 8'h03, 8'hA1, 8'h03, 3, 0, 3, 0, 8'h00, 8'h00, 0, 0, 0, 8'h80, -1};
        vecs[2] = '{"sis",     8'h08, 8'h00, 8'h00, 1, 0, 1, 2, 8'h20, 8'h05, 2, 0, 0, 8'h80, -1};
        vecs[3] = '{"invalid", 8'h1F, 8'h00, 8'h00, 3, 0, 1, 1, 8'h80, 8'h00, 1, 0, 1, 8'h80, -1};
        vecs[4] = '{"timeout", 8'h08, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h10, 16};

        rst = 1'b1; cmd_wr = 1'b0; cmd_data = 8'h00; start = 1'b0; res_idx = 3'd0;
        m_reset(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_rd_n",  {31'd0, fdc.fdc_rd_n}, 32'd1);
        chk("rst_wr_n",  {31'd0, fdc.fdc_wr_n}, 32'd1);
        chk("rst_ce",    {31'd0, fdc.fdc_ce},   32'd0);
        chk("rst_a0",    {31'd0, fdc.fdc_a0},   32'd0);
        chk("rst_dout",  {24'd0, fdc.fdc_dout}, 32'd0);
        chk("rst_flags", {28'd0, busy, done, timeout, early_result}, 32'd0);
        chk("rst_count", {28'd0, res_count},    32'd0);
        chk("rst_rdata", {24'd0, res_data},     32'd0);

        // Table-driven commands
        for (int i = 0; i < 5; i++) begin
            m_reset(vecs[i].stuck);
            done_cnt = 0;
            push(vecs[i].b0);
            if (vecs[i].n > 1) push(vecs[i].b1);
            if (vecs[i].n > 2) push(vecs[i].b2);
            pulse_start();
            wait_done(vecs[i].name);
            repeat (3) @(negedge clk);
            chk({vecs[i].name, "_done_cnt"}, done_cnt, 32'd1);
            chk({vecs[i].name, "_writes"},   m_writes, vecs[i].exp_wr);
            chk({vecs[i].name, "_res_count"}, {28'd0, res_count}, vecs[i].exp_cnt);
            chk({vecs[i].name, "_timeout"},  {31'd0, timeout}, {31'd0, vecs[i].exp_to});
            chk({vecs[i].name, "_early"},    {31'd0, early_result}, {31'd0, vecs[i].exp_early});
            chk({vecs[i].name, "_last_msr"}, {24'd0, m_last_msr}, {24'd0, vecs[i].exp_last});
            chk({vecs[i].name, "_bus_idle"},
                {28'd0, fdc.fdc_rd_n, fdc.fdc_wr_n, fdc.fdc_ce, busy}, 32'b1100);
            if (vecs[i].exp_reads >= 0)
                chk({vecs[i].name, "_msr_reads"}, m_msr_reads, vecs[i].exp_reads);
            if (vecs[i].nchk >= 1) begin
                read_res(3'd0, rv);
                chk({vecs[i].name, "_res0"}, {24'd0, rv}, {24'd0, vecs[i].r0});
            end
            if (vecs[i].nchk >= 2) begin
                read_res(3'd1, rv);
                chk({vecs[i].name, "_res1"}, {24'd0, rv}, {24'd0, vecs[i].r1});
            end
        end

        // Timeout flag held until next start; empty start completes next cycle
        chk("timeout_held", {31'd0, timeout}, 32'd1);
        m_reset(0);
        done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("empty_done_next", {31'd0, done}, 32'd1);
        chk("empty_timeout_clr", {31'd0, timeout}, 32'd0);
        chk("empty_res_count", {28'd0, res_count}, 32'd0);
        @(negedge clk);
        chk("empty_done_single", {31'd0, done}, 32'd0);

        // cmd_wr and start ignored while busy
        m_reset(0);
        done_cnt = 0;
        push(8'h08);
        pulse_start();
        repeat (3) @(negedge clk);
        chk("busy_set", {31'd0, busy}, 32'd1);
        push(8'h55);
        pulse_start();
        wait_done("busy_run");
        repeat (3) @(negedge clk);
        chk("busy_done_cnt", done_cnt, 32'd1);
        chk("busy_writes", m_writes, 32'd1);
        chk("busy_res_count", {28'd0, res_count}, 32'd2);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("buf_cleared_done", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
        chk("buf_cleared_writes", m_writes, 32'd1);

        // Reset in the middle of a write strobe
        m_reset(0);
        push(8'h03); push(8'hA1); push(8'h03);
        pulse_start();
        n = 0;
        while (fdc.fdc_wr_n !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        chk("midwr_strobe_seen", {31'd0, fdc.fdc_wr_n}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midwr_wr_n", {31'd0, fdc.fdc_wr_n}, 32'd1);
        chk("midwr_ce",   {31'd0, fdc.fdc_ce},   32'd0);
        chk("midwr_busy", {31'd0, busy},         32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midwr_idle", {28'd0, fdc.fdc_rd_n, fdc.fdc_wr_n, fdc.fdc_ce, busy}, 32'b1100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
